// File: rtl/gsim_pkg.sv
// Shared types and constants for the parametrised Gauss-Seidel solver.
// Banded system: diag 20, off-diagonals -13 / +6 / -1.
package gsim_pkg;

    typedef enum logic [1:0] {
        RECV = 2'd0,
        CALC = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam int C1       = 13;
    localparam int C2       = 6;
    localparam int C3       = 1;
    localparam int RECIP    = 52429;   // round(2^20 / 20)
    localparam int RECIP_SH = 20;
    localparam int FRAC     = 16;

endpackage

// File: rtl/gsim_solver_param_if.sv
// b-vector load stream and x-result stream of the solver.
// master = loader/consumer side, slave = solver side.
interface gsim_solver_param_if #(
    parameter int N   = 16,
    parameter int B_W = 16,
    parameter int X_W = 32
);
    localparam int IDX_W = $clog2(N);

    logic                   in_en;
    logic signed [B_W-1:0]  b_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [X_W-1:0]         x_out;
    logic [IDX_W-1:0]       out_idx;

    modport master (
        output in_en, b_in, out_ready,
        input  out_valid, x_out, out_idx
    );

    modport slave (
        input  in_en, b_in, out_ready,
        output out_valid, x_out, out_idx
    );

endinterface

// File: rtl/gsim_update_dp.sv
// Combinational single-unknown update: 7-entry x window plus b_i -> x_new and |x_new - x_old|.
// All constant multiplies are shift-add trees driven by the package constants.
module gsim_update_dp
    import gsim_pkg::*;
#(
    parameter int B_W = 16,
    parameter int X_W = 32
)(
    input  logic signed [B_W-1:0]  b,
    input  logic [6:0][X_W-1:0]    x_win,
    output logic [X_W-1:0]         x_new,
    output logic [X_W:0]           d_abs
);
    localparam int NUM_W  = X_W + 8;
    localparam int PROD_W = NUM_W + 17;

    logic [6:0][NUM_W-1:0]    x_ext;
    logic [2:0][NUM_W-1:0]    term;
    logic signed [NUM_W-1:0]  num;
    logic signed [PROD_W-1:0] prod;
    logic signed [X_W:0]      diff;
    logic                     unused_prod;

    for (genvar gi = 0; gi < 7; gi++) begin : g_ext
        assign x_ext[gi] = {{(NUM_W-X_W){x_win[gi][X_W-1]}}, x_win[gi]};
    end

    // term[k-1] = C_k * (x[i-k] + x[i+k]); window slot 3 is x[i] itself
    for (genvar gi = 0; gi < 3; gi++) begin : g_coef
        localparam int COEF = (gi == 0) ? C1 : (gi == 1) ? C2 : C3;
        logic signed [NUM_W-1:0] pair;
        logic signed [NUM_W-1:0] acc;

        assign pair = $signed(x_ext[2-gi]) + $signed(x_ext[4+gi]);

        always_comb begin
            acc = '0;
            for (int s = 0; s < 4; s++) begin
                if (((COEF >> s) & 1) == 1) acc = acc + (pair <<< s);
            end
        end

        assign term[gi] = acc;
    end

    always_comb begin
        num  = $signed({{(NUM_W-B_W){b[B_W-1]}}, b}) <<< FRAC;
        num  = num + $signed(term[0]) - $signed(term[1]) + $signed(term[2]);
        prod = '0;
        for (int s = 0; s < 17; s++) begin
            if (((RECIP >> s) & 1) == 1)
                prod = prod + ($signed({{(PROD_W-NUM_W){num[NUM_W-1]}}, num}) <<< s);
        end
    end

    // Taking the bit window above RECIP_SH is the floor of the arithmetic shift.
    assign x_new       = prod[RECIP_SH +: X_W];
    assign unused_prod = ^{prod[PROD_W-1:RECIP_SH+X_W], prod[RECIP_SH-1:0]};

    assign diff  = $signed({x_new[X_W-1], x_new}) - $signed({x_win[3][X_W-1], x_win[3]});
    assign d_abs = diff[X_W] ? -diff : diff;

endmodule

// File: rtl/gsim_solver_param.sv
// Parametrised Gauss-Seidel solver: loads N b values, runs in-place sweeps
// (one unknown per cycle) with optional tolerance exit, then streams x out.
module gsim_solver_param
    import gsim_pkg::*;
#(
    parameter int N      = 16,
    parameter int B_W    = 16,
    parameter int X_W    = 32,
    parameter int ITER_W = 8
)(
    input  logic               clk,
    input  logic               reset,
    gsim_solver_param_if.slave bus,
    input  logic [ITER_W-1:0]  iter_max,
    input  logic               tol_en,
    input  logic [X_W-1:0]     tol,
    output logic               busy,
    output logic [ITER_W-1:0]  iter_used,
    output logic               converged
);
    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N-1);
    localparam logic signed [IDX_W+1:0] N_S = (IDX_W+2)'(N);

    state_t                 state_reg, state_next;
    logic [IDX_W-1:0]       idx_reg;
    logic [ITER_W-1:0]      iter_reg, iter_max_reg, iter_inc;
    logic                   tol_en_reg, conv_reg;
    logic [X_W-1:0]         tol_reg;
    logic [X_W:0]           dmax_reg, dmax_cur;
    logic signed [B_W-1:0]  b_reg [N];
    logic signed [X_W-1:0]  x_reg [N];

    logic [6:0][X_W-1:0]    x_win;
    logic [X_W-1:0]         x_new;
    logic [X_W:0]           d_abs;
    logic                   sweep_end, tol_hit, calc_done;

    // Neighbour window around idx_reg; positions outside 0..N-1 read as zero.
    for (genvar gi = 0; gi < 7; gi++) begin : g_win
        logic signed [IDX_W+1:0] pos;
        logic                    in_rng;
        assign pos       = $signed({2'b00, idx_reg}) + $signed((IDX_W+2)'(gi - 3));
        assign in_rng    = !pos[IDX_W+1] && (pos < N_S);
        assign x_win[gi] = in_rng ? x_reg[pos[IDX_W-1:0]] : '0;
    end

    gsim_update_dp #(.B_W(B_W), .X_W(X_W)) u_dp (
        .b     (b_reg[idx_reg]),
        .x_win (x_win),
        .x_new (x_new),
        .d_abs (d_abs)
    );

    assign iter_inc  = iter_reg + ITER_W'(1);
    assign dmax_cur  = (d_abs > dmax_reg) ? d_abs : dmax_reg;
    assign tol_hit   = tol_en_reg && (dmax_cur <= {1'b0, tol_reg});
    assign sweep_end = (state_reg == CALC) && (idx_reg == LAST);
    assign calc_done = sweep_end && ((iter_inc == iter_max_reg) || tol_hit);

    always_ff @(posedge clk) begin
        if (!reset) state_reg <= RECV;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RECV: if (bus.in_en && idx_reg == LAST)
                      state_next = (iter_max == '0) ? SEND : CALC;
            CALC: if (calc_done) state_next = SEND;
            SEND: if (bus.out_ready && idx_reg == LAST) state_next = RECV;
            default: state_next = RECV;
        endcase
    end

    always_comb begin
        busy          = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_idx   = '0;
        bus.x_out     = '0;
        if (state_reg != RECV) busy = 1'b1;
        if (state_reg == SEND) begin
            bus.out_valid = 1'b1;
            bus.out_idx   = idx_reg;
            bus.x_out     = x_reg[idx_reg];
        end
    end

    assign iter_used = iter_reg;
    assign converged = conv_reg;

    // idx_reg is the load counter in RECV, the unknown index in CALC and the output index in SEND.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_reg      <= '0;
            iter_reg     <= '0;
            iter_max_reg <= '0;
            tol_en_reg   <= 1'b0;
            tol_reg      <= '0;
            conv_reg     <= 1'b0;
            dmax_reg     <= '0;
            for (int i = 0; i < N; i++) begin
                b_reg[i] <= '0;
                x_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                RECV: if (bus.in_en) begin
                    b_reg[idx_reg] <= bus.b_in;
                    if (idx_reg == LAST) begin
                        idx_reg      <= '0;
                        iter_max_reg <= iter_max;
                        tol_en_reg   <= tol_en;
                        tol_reg      <= tol;
                        iter_reg     <= '0;
                        conv_reg     <= 1'b0;
                        dmax_reg     <= '0;
                        for (int i = 0; i < N; i++) x_reg[i] <= '0;
                    end else begin
                        idx_reg <= idx_reg + IDX_W'(1);
                    end
                end
                CALC: begin
                    x_reg[idx_reg] <= x_new;
                    if (sweep_end) begin
                        idx_reg  <= '0;
                        dmax_reg <= '0;
                        iter_reg <= iter_inc;
                        if (calc_done) conv_reg <= tol_hit;
                    end else begin
                        idx_reg  <= idx_reg + IDX_W'(1);
                        dmax_reg <= dmax_cur;
                    end
                end
                SEND: if (bus.out_ready) begin
                    idx_reg <= (idx_reg == LAST) ? '0 : idx_reg + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gsim_solver_param.sv
// Scoreboard bench for gsim_solver_param: a reference model fills the expected
// x stream at load time; a negedge monitor pops and compares every transfer.
module tb_gsim_solver_param;
    localparam int N      = 16;
    localparam int B_W    = 16;
    localparam int X_W    = 32;
    localparam int ITER_W = 8;

    typedef struct {
        int          idx;
        logic [31:0] x;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [ITER_W-1:0] iter_max;
    logic              tol_en;
    logic [X_W-1:0]    tol;
    logic              busy;
    logic [ITER_W-1:0] iter_used;
    logic              converged;

    gsim_solver_param_if #(.N(N), .B_W(B_W), .X_W(X_W)) bus ();

    gsim_solver_param #(.N(N), .B_W(B_W), .X_W(X_W), .ITER_W(ITER_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .iter_max  (iter_max),
        .tol_en    (tol_en),
        .tol       (tol),
        .busy      (busy),
        .iter_used (iter_used),
        .converged (converged)
    );

    always #5 clk = ~clk;

    int                err_cnt = 0;
    int                chk_cnt = 0;
    int                n_xfer  = 0;
    logic signed [15:0] b_vec [N];
    int                cfg_iter;
    bit                cfg_tol_en;
    logic [31:0]       cfg_tol;
    longint            mx [N];
    int                exp_iter;
    bit                exp_conv;
    exp_t              sb_q [$];
    exp_t              mon_e;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint xat(int j);
        if (j < 0 || j >= N) return 0;
        return mx[j];
    endfunction

    // Reference: plain integer Gauss-Seidel with floor division by the reciprocal.
    task automatic model_run();
        longint num, xn, d, dmax;
        int     it;
        bit     tol_ok;
        for (int i = 0; i < N; i++) mx[i] = 0;
        it = 0;
        exp_conv = 1'b0;
        if (cfg_iter != 0) begin
            while (1) begin
                dmax = 0;
                for (int i = 0; i < N; i++) begin
                    num = (longint'(b_vec[i]) <<< 16)
                        + 13 * (xat(i-1) + xat(i+1))
                        -  6 * (xat(i-2) + xat(i+2))
                        +      (xat(i-3) + xat(i+3));
                    xn = (num * 52429) >>> 20;
                    xn = longint'(int'(xn));
                    d  = xn - mx[i];
                    if (d < 0) d = -d;
                    if (d > dmax) dmax = d;
                    mx[i] = xn;
                end
                it++;
                tol_ok = cfg_tol_en && (dmax <= longint'(cfg_tol));
                if (it == cfg_iter || tol_ok) begin
                    exp_conv = tol_ok;
                    break;
                end
            end
        end
        exp_iter = it;
    endtask

    task automatic load_job();
        iter_max = ITER_W'(cfg_iter);
        tol_en   = cfg_tol_en;
        tol      = cfg_tol;
        model_run();
        for (int i = 0; i < N; i++) sb_q.push_back('{idx: i, x: mx[i][31:0]});
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            bus.in_en = 1'b1;
            bus.b_in  = b_vec[k];
        end
        @(negedge clk);
        bus.in_en = 1'b0;
    endtask

    task automatic finish_job(input string tag);
        check_eq({tag, "_busy_end"},  64'(busy), 64'(0));
        check_eq({tag, "_valid_end"}, 64'(bus.out_valid), 64'(0));
        check_eq({tag, "_iter_used"}, 64'(iter_used), 64'(exp_iter));
        check_eq({tag, "_converged"}, 64'(converged), 64'(exp_conv));
        $display("job %s: iter_used=%0d converged=%0d transfers=%0d", tag, iter_used, converged, n_xfer);
    endtask

    task automatic wait_done(input string tag, input bit rand_ready, input int max_cyc);
        int cyc = 0;
        while (sb_q.size() != 0 && cyc < max_cyc) begin
            @(posedge clk);
            #1;
            cyc++;
            if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
        end
        check_eq({tag, "_drained"}, 64'(sb_q.size()), 64'(0));
        sb_q.delete();
        bus.out_ready = 1'b1;
        finish_job(tag);
    endtask

    task automatic fill_b(input int lo, input int hi);
        for (int i = 0; i < N; i++) b_vec[i] = 16'($urandom_range(0, hi - lo) + lo);
    endtask

    // Transfer happens at the next posedge when both are high at this negedge.
    always @(negedge clk) begin
        if (reset && bus.out_valid && bus.out_ready) begin
            n_xfer++;
            if (sb_q.size() == 0) begin
                check_eq("sb_underflow", 64'(sb_q.size()), 64'(1));
            end else begin
                mon_e = sb_q.pop_front();
                check_eq($sformatf("x_out[%0d]", mon_e.idx), 64'(bus.x_out), 64'(mon_e.x));
                check_eq($sformatf("out_idx[%0d]", mon_e.idx), 64'(bus.out_idx), 64'(mon_e.idx));
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, cyc, saved_iter;
        reset = 1'b0; bus.in_en = 1'b0; bus.b_in = '0; bus.out_ready = 1'b1;
        iter_max = '0; tol_en = 1'b0; tol = '0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy",      64'(busy), 64'(0));
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check_eq("rst_x_out",     64'(bus.x_out), 64'(0));
        check_eq("rst_out_idx",   64'(bus.out_idx), 64'(0));
        check_eq("rst_iter_used", 64'(iter_used), 64'(0));
        check_eq("rst_converged", 64'(converged), 64'(0));
        @(negedge clk);
        reset = 1'b1;

        // t1: zero b, fixed 5 sweeps, random back-pressure
        for (int i = 0; i < N; i++) b_vec[i] = '0;
        cfg_iter = 5; cfg_tol_en = 1'b0; cfg_tol = '0;
        load_job();
        wait_done("t1", 1'b1, 2000);

        // t2: single nonzero b, one sweep
        for (int i = 0; i < N; i++) b_vec[i] = '0;
        b_vec[0] = 16'sd20;
        cfg_iter = 1; cfg_tol_en = 1'b0; cfg_tol = '0;
        load_job();
        wait_done("t2", 1'b0, 2000);

        // t3: exact-convergence exit, then fixed-count rerun with the same sweep count
        for (int i = 0; i < N; i++) b_vec[i] = 16'sd20;
        cfg_iter = 255; cfg_tol_en = 1'b1; cfg_tol = '0;
        load_job();
        wait_done("t3a", 1'b0, 10000);
        saved_iter = exp_iter;
        cfg_iter = saved_iter; cfg_tol_en = 1'b0;
        load_job();
        wait_done("t3b", 1'b0, 10000);

        // t4: stall the consumer at k=3 for 10 cycles
        fill_b(-100, 100);
        cfg_iter = 3; cfg_tol_en = 1'b0; cfg_tol = '0;
        bus.out_ready = 1'b1;
        base = n_xfer;
        load_job();
        cyc = 0;
        while (n_xfer < base + 3 && cyc < 2000) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check_eq("t4_reach_k3", 64'(n_xfer - base), 64'(3));
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_eq("t4_hold_valid", 64'(bus.out_valid), 64'(1));
            check_eq("t4_hold_idx",   64'(bus.out_idx), 64'(3));
            check_eq("t4_hold_x",     64'(bus.x_out), 64'(sb_q[0].x));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        cyc = 0;
        while (sb_q.size() != 0 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq("t4_burst_cycles", 64'(cyc), 64'(13));
        finish_job("t4");

        // t5: reset in the middle of sweep 2, then a clean solve
        fill_b(-50, 50);
        cfg_iter = 5; cfg_tol_en = 1'b0; cfg_tol = '0;
        load_job();
        repeat (N + 4) @(negedge clk);
        reset = 1'b0;
        sb_q.delete();
        @(posedge clk);
        #1;
        check_eq("t5_busy",      64'(busy), 64'(0));
        check_eq("t5_out_valid", 64'(bus.out_valid), 64'(0));
        check_eq("t5_x_out",     64'(bus.x_out), 64'(0));
        check_eq("t5_out_idx",   64'(bus.out_idx), 64'(0));
        check_eq("t5_iter_used", 64'(iter_used), 64'(0));
        check_eq("t5_converged", 64'(converged), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("t5_idle_valid", 64'(bus.out_valid), 64'(0));
        fill_b(-80, 80);
        cfg_iter = 3;
        load_job();
        wait_done("t5", 1'b0, 2000);

        // t6: zero sweeps; stray in_en during SEND must not count as a load
        fill_b(-80, 80);
        cfg_iter = 0; cfg_tol_en = 1'b0; cfg_tol = '0;
        bus.out_ready = 1'b0;
        load_job();
        check_eq("t6_valid_now", 64'(bus.out_valid), 64'(1));
        check_eq("t6_busy_now",  64'(busy), 64'(1));
        check_eq("t6_iter_now",  64'(iter_used), 64'(0));
        repeat (4) begin
            @(negedge clk);
            bus.in_en = 1'b1;
            bus.b_in  = 16'($urandom);
        end
        @(negedge clk);
        bus.in_en = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_done("t6", 1'b0, 2000);

        // t7: stray in_en during CALC
        fill_b(-100, 100);
        cfg_iter = 2;
        load_job();
        repeat (5) begin
            @(negedge clk);
            bus.in_en = 1'b1;
            bus.b_in  = 16'($urandom);
        end
        @(negedge clk);
        bus.in_en = 1'b0;
        wait_done("t7", 1'b1, 2000);

        // t8: nonzero tolerance exit on a fresh load
        fill_b(-100, 100);
        cfg_iter = 200; cfg_tol_en = 1'b1; cfg_tol = 32'h0000_0400;
        load_job();
        wait_done("t8", 1'b1, 10000);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
